// File: rtl/subtrator_serial.sv
// rtl/subtrator_serial.sv - digit-serial subtractor d = a - b - bin with valid/ready handshake
module subtrator_serial #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   d,
    output logic             busy
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             borrow;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   result;
    logic [DIGIT:0]   digit_diff;
    logic             last_digit;

    // One digit of subtraction; the extra top bit of the difference is the borrow out.
    always_comb begin
        digit_diff = {1'b0, a_sh[DIGIT-1:0]} - {1'b0, b_sh[DIGIT-1:0]}
                   - {{DIGIT{1'b0}}, borrow};
        last_digit = (cnt == CW'(N - 1));
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and state-only handshake outputs.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = S_CALC;
                end
            end
            S_CALC: begin
                busy = 1'b1;
                if (last_digit) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Operand shifters, borrow, digit counter and result accumulation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
            result <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        a_sh   <= a;
                        b_sh   <= b;
                        borrow <= bin;
                        cnt    <= '0;
                        result <= '0;
                    end
                end
                S_CALC: begin
                    for (int i = 0; i < N; i++) begin
                        if (cnt == CW'(i)) begin
                            result[i*DIGIT +: DIGIT] <= digit_diff[DIGIT-1:0];
                        end
                    end
                    if (last_digit) begin
                        result[WIDTH] <= digit_diff[DIGIT];
                    end
                    borrow <= digit_diff[DIGIT];
                    a_sh   <= a_sh >> DIGIT;
                    b_sh   <= b_sh >> DIGIT;
                    cnt    <= cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

    // The result register is the output; it holds until the next acceptance.
    always_comb begin
        d = result;
    end

endmodule

// File: tb/tb_subtrator_serial.sv
// tb/tb_subtrator_serial.sv - table-driven scoreboard bench for subtrator_serial
module tb_subtrator_serial;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    // instance 0: WIDTH=8 DIGIT=1
    logic iv0 = 0, ir0, bin0 = 0, ov0, or0 = 0, busy0;
    logic [7:0] a0 = '0, b0 = '0;
    logic [8:0] d0;
    // instance 1: WIDTH=16 DIGIT=4
    logic iv1 = 0, ir1, bin1 = 0, ov1, or1 = 0, busy1;
    logic [15:0] a1 = '0, b1 = '0;
    logic [16:0] d1;
    // instance 2: WIDTH=16 DIGIT=16
    logic iv2 = 0, ir2, bin2 = 0, ov2, or2 = 0, busy2;
    logic [15:0] a2 = '0, b2 = '0;
    logic [16:0] d2;

    subtrator_serial #(.WIDTH(8), .DIGIT(1)) u_w8d1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .a(a0), .b(b0), .bin(bin0),
        .out_valid(ov0), .out_ready(or0), .d(d0), .busy(busy0));
    subtrator_serial #(.WIDTH(16), .DIGIT(4)) u_w16d4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1), .bin(bin1),
        .out_valid(ov1), .out_ready(or1), .d(d1), .busy(busy1));
    subtrator_serial #(.WIDTH(16), .DIGIT(16)) u_w16d16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .a(a2), .b(b2), .bin(bin2),
        .out_valid(ov2), .out_ready(or2), .d(d2), .busy(busy2));

    always #5 clk = ~clk;

    typedef struct {
        int          sel;
        logic [15:0] a;
        logic [15:0] b;
        logic        bin;
        logic [16:0] exp_d;
        int          hold;
        bit          keep;
    } vec_t;

    vec_t        vecs[$];
    logic [16:0] sb_q[$];
    int          tests = 0;
    int          fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int ndig(input int sel);
        return (sel == 0) ? 8 : (sel == 1) ? 4 : 1;
    endfunction

    function automatic logic [16:0] model(input int sel, input logic [15:0] a, input logic [15:0] b,
                                          input logic bin);
        logic [31:0] x;
        if (sel == 0) begin
            x = {24'd0, a[7:0]} - {24'd0, b[7:0]} - {31'd0, bin};
            return {8'd0, x[8:0]};
        end
        x = {16'd0, a} - {16'd0, b} - {31'd0, bin};
        return x[16:0];
    endfunction

    function automatic logic get_ov(input int sel);
        return (sel == 0) ? ov0 : (sel == 1) ? ov1 : ov2;
    endfunction
    function automatic logic get_ir(input int sel);
        return (sel == 0) ? ir0 : (sel == 1) ? ir1 : ir2;
    endfunction
    function automatic logic get_busy(input int sel);
        return (sel == 0) ? busy0 : (sel == 1) ? busy1 : busy2;
    endfunction
    function automatic logic [16:0] get_d(input int sel);
        return (sel == 0) ? {8'd0, d0} : (sel == 1) ? d1 : d2;
    endfunction

    task automatic set_in(input int sel, input logic v, input logic [15:0] a, input logic [15:0] b,
                          input logic bin);
        case (sel)
            0: begin iv0 = v; a0 = a[7:0]; b0 = b[7:0]; bin0 = bin; end
            1: begin iv1 = v; a1 = a; b1 = b; bin1 = bin; end
            default: begin iv2 = v; a2 = a; b2 = b; bin2 = bin; end
        endcase
    endtask

    task automatic set_or(input int sel, input logic v);
        case (sel)
            0: or0 = v;
            1: or1 = v;
            default: or2 = v;
        endcase
    endtask

    task automatic scramble(input int sel);
        logic [15:0] ra, rb;
        ra = 16'($urandom);
        rb = 16'($urandom);
        set_in(sel, 1'b1, ra, rb, 1'($urandom_range(0, 1)));
    endtask

    // Called at a negedge with the instance idle; returns at a negedge after the result handshake.
    task automatic run_op(input int sel, input logic [15:0] a, input logic [15:0] b, input logic bin,
                          input logic [16:0] exp_d, input int hold, input bit keep);
        logic [16:0] d_hold;
        logic [16:0] exp;
        int edges;
        set_in(sel, 1'b1, a, b, bin);
        check("in_ready_idle", 32'(get_ir(sel)), 1);
        sb_q.push_back(exp_d);
        @(posedge clk);
        @(negedge clk);
        edges = 1;
        if (keep) scramble(sel);
        else set_in(sel, 1'b0, a, b, bin);
        while (!get_ov(sel) && edges < 64) begin
            check("busy_calc", 32'(get_busy(sel)), 1);
            check("in_ready_calc", 32'(get_ir(sel)), 0);
            @(posedge clk);
            @(negedge clk);
            edges++;
            if (keep) scramble(sel);
        end
        check("out_valid_rise", 32'(get_ov(sel)), 1);
        check("latency", 32'(edges), 32'(ndig(sel) + 1));
        check("busy_done", 32'(get_busy(sel)), 0);
        check("in_ready_done", 32'(get_ir(sel)), 0);
        d_hold = get_d(sel);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("d_stable", 32'(get_d(sel)), 32'(d_hold));
            check("out_valid_hold", 32'(get_ov(sel)), 1);
            if (keep) scramble(sel);
        end
        set_in(sel, 1'b0, a, b, bin);
        set_or(sel, 1'b1);
        if (sb_q.size() == 0) begin
            check("scoreboard_empty", 1, 0);
        end else begin
            exp = sb_q.pop_front();
            check($sformatf("d_result_sel%0d", sel), 32'(get_d(sel)), 32'(exp));
        end
        @(posedge clk);
        @(negedge clk);
        set_or(sel, 1'b0);
        check("out_valid_drop", 32'(get_ov(sel)), 0);
        check("in_ready_back", 32'(get_ir(sel)), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        vecs.push_back('{0, 16'h005A, 16'h0023, 1'b0, 17'h00037, 5, 1'b0});
        vecs.push_back('{0, 16'h0000, 16'h0001, 1'b0, 17'h001FF, 0, 1'b0});
        vecs.push_back('{0, 16'h0010, 16'h0010, 1'b1, 17'h001FF, 0, 1'b0});
        vecs.push_back('{0, 16'h00FF, 16'h0000, 1'b1, 17'h000FE, 0, 1'b0});
        vecs.push_back('{1, 16'h1234, 16'h0FFF, 1'b0, 17'h00235, 2, 1'b0});
        vecs.push_back('{2, 16'h1234, 16'h0FFF, 1'b0, 17'h00235, 2, 1'b0});
        vecs.push_back('{0, 16'h00C3, 16'h003C, 1'b0, 17'h00087, 3, 1'b1});
        vecs.push_back('{0, 16'h0001, 16'h0002, 1'b1, 17'h001FE, 0, 1'b0});
        vecs.push_back('{1, 16'h0000, 16'hFFFF, 1'b1, 17'h10000, 0, 1'b1});
        vecs.push_back('{2, 16'hFFFF, 16'hFFFF, 1'b0, 17'h00000, 1, 1'b1});
        vecs.push_back('{1, 16'hFFFF, 16'h0001, 1'b1, 17'h0FFFD, 0, 1'b0});

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            check("rst_d", 32'(get_d(s)), 0);
            check("rst_out_valid", 32'(get_ov(s)), 0);
            check("rst_in_ready", 32'(get_ir(s)), 1);
            check("rst_busy", 32'(get_busy(s)), 0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            run_op(vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].exp_d,
                   vecs[i].hold, vecs[i].keep);
        end

        // mid-operation reset: instances 0/1 in CALC, instance 2 in DONE
        set_in(0, 1'b1, 16'h00AA, 16'h0011, 1'b0);
        set_in(1, 1'b1, 16'hAAAA, 16'h1111, 1'b0);
        set_in(2, 1'b1, 16'hAAAA, 16'h1111, 1'b0);
        @(posedge clk);
        @(negedge clk);
        set_in(0, 1'b0, 16'h0, 16'h0, 1'b0);
        set_in(1, 1'b0, 16'h0, 16'h0, 1'b0);
        set_in(2, 1'b0, 16'h0, 16'h0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("pre_rst_busy0", 32'(busy0), 1);
        check("pre_rst_ov2", 32'(ov2), 1);
        #2 rst_n = 1'b0;
        #1;
        for (int s = 0; s < 3; s++) begin
            check("midrst_d", 32'(get_d(s)), 0);
            check("midrst_out_valid", 32'(get_ov(s)), 0);
            check("midrst_in_ready", 32'(get_ir(s)), 1);
            check("midrst_busy", 32'(get_busy(s)), 0);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (ov0 || ov1 || ov2) seen = 1;
        end
        check("no_out_valid_after_reset", 32'(seen), 0);
        run_op(0, 16'h0080, 16'h007F, 1'b0, 17'h00001, 0, 1'b0);

        // random operands against the reference model
        for (int i = 0; i < 18; i++) begin
            logic [15:0] ra, rb;
            logic rbin;
            int s;
            s = i % 3;
            ra = 16'($urandom);
            rb = 16'($urandom);
            rbin = 1'($urandom_range(0, 1));
            run_op(s, ra, rb, rbin, model(s, ra, rb, rbin), 0, 1'b0);
        end

        check("scoreboard_drained", 32'(sb_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
